// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// This package holds the FSM state encoding and the nibble slice width.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        int w;
        w = $clog2(nibbles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_add_slice.sv
// Combinational 4-bit ripple-carry adder slice.
// The controller reuses this one slice for every nibble of an operation.
module nibble_add_slice
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    always_comb begin
        logic carry;
        s     = '0;
        carry = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Multi-precision add/subtract sequencer: one nibble per cycle, LSB first,
// with the inter-nibble carry held in a flop.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one nibble added per cycle, NIBBLES cycles in total
// DONE  | one-cycle done pulse, result/flags already registered
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IW      = idx_width(NIBBLES);

    localparam logic [1:0]    IDLE     = ST_IDLE;
    localparam logic [1:0]    RUN      = ST_RUN;
    localparam logic [1:0]    DONE     = ST_DONE;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
            $error("nibble_serial_add_ctrl: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry_reg;
    logic [IW-1:0]    idx;

    logic [NIBBLE_W-1:0]       slice_s;
    logic                      slice_cout;
    logic [WIDTH+NIBBLE_W-1:0] acc_ext;
    logic [WIDTH-1:0]          acc_next;
    logic                      last_nibble;
    logic                      ovf_next;

    nibble_add_slice u_slice (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Each new sum nibble enters at the MSB end, so after NIBBLES shifts the
    // first nibble has arrived at bit 0.
    always_comb begin
        acc_ext     = {slice_s, acc};
        acc_next    = acc_ext[WIDTH+NIBBLE_W-1:NIBBLE_W];
        last_nibble = (state == RUN) && (idx == LAST_IDX);
        ovf_next    = (a_sh[NIBBLE_W-1] ^ b_sh[NIBBLE_W-1] ^ slice_s[NIBBLE_W-1])
                      ^ slice_cout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh      <= op_a;
                        b_sh      <= sub ? ~op_b : op_b;
                        carry_reg <= sub ? 1'b1 : carry_in;
                        acc       <= '0;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    a_sh      <= a_sh >> NIBBLE_W;
                    b_sh      <= b_sh >> NIBBLE_W;
                    acc       <= acc_next;
                    carry_reg <= slice_cout;
                    idx       <= idx + IW'(1);
                    if (last_nibble) begin
                        state     <= DONE;
                        idx       <= '0;
                        result    <= acc_next;
                        carry_out <= slice_cout;
                        overflow  <= ovf_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (WIDTH=16 and WIDTH=4 builds)
// against an arithmetic reference model.
module tb_nibble_serial_add_ctrl;

    localparam int W  = 16;
    localparam int N  = W / 4;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        v;
        longint      due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 0, sub = 0, carry_in = 0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic          busy, done, carry_out, overflow;
    logic [W-1:0]  result;

    logic          start4 = 0, sub4 = 0, carry_in4 = 0;
    logic [3:0]    op_a4 = '0, op_b4 = '0;
    logic          busy4, done4, carry_out4, overflow4;
    logic [3:0]    result4;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b), .carry_in(carry_in),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4),
        .op_a(op_a4), .op_b(op_b4), .carry_in(carry_in4),
        .busy(busy4), .done(done4), .result(result4),
        .carry_out(carry_out4), .overflow(overflow4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer sum, sign-rule overflow.
    function automatic exp_t ref_op(input int w, input logic s, input longint a,
                                    input longint b, input logic ci);
        exp_t   r;
        longint mask, bb, sum, sa, sb, sr;
        mask  = (longint'(1) << w) - 1;
        bb    = s ? (~b & mask) : b;
        sum   = a + bb + (s ? 1 : longint'(ci));
        r.res = 16'(sum & mask);
        r.c   = ((sum >> w) & 1) != 0;
        sa    = (a >> (w - 1)) & 1;
        sb    = (b >> (w - 1)) & 1;
        sr    = (longint'(r.res) >> (w - 1)) & 1;
        r.v   = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        r.due = 0;
        return r;
    endfunction

    exp_t   q[$];
    exp_t   q4[$];
    int     cnt = 0, cnt4 = 0;
    longint cyc = 0, cyc4 = 0;
    exp_t   held;

    // Acceptance model: a request is taken only when the previous one has
    // fully drained (NIBBLES run cycles plus the done cycle).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt = 0;
            q.delete();
        end else begin
            cyc++;
            if (cnt > 0) cnt--;
            else if (start) begin
                exp_t e;
                e     = ref_op(W, sub, longint'(op_a), longint'(op_b), carry_in);
                e.due = cyc + N;
                q.push_back(e);
                cnt   = N + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt4 = 0;
            q4.delete();
        end else begin
            cyc4++;
            if (cnt4 > 0) cnt4--;
            else if (start4) begin
                exp_t e;
                e     = ref_op(4, sub4, longint'(op_a4), longint'(op_b4), carry_in4);
                e.due = cyc4 + 1;
                q4.push_back(e);
                cnt4  = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held = '{res: 16'h0, c: 1'b0, v: 1'b0, due: 0};
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_result", result, 0);
            check("rst_carry", carry_out, 0);
            check("rst_ovf", overflow, 0);
        end else begin
            check("busy", busy, cnt >= 2);
            check("done", done, cnt == 1);
            if (done) begin
                if (q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    held = q.pop_front();
                    check("latency", cyc, held.due);
                end
            end
            check("result", result, held.res);
            check("carry_out", carry_out, held.c);
            check("overflow", overflow, held.v);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy4", busy4, cnt4 == 2);
            if (done4) begin
                if (q4.size() == 0) check("done4_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = q4.pop_front();
                    check("latency4", cyc4, e.due);
                    check("result4", result4, e.res);
                    check("carry4", carry_out4, e.c);
                    check("ovf4", overflow4, e.v);
                end
            end
        end
    end

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        @(negedge clk);
        start = 1; sub = s; op_a = a; op_b = b; carry_in = ci;
        @(negedge clk);
        start = 0; op_a = W'($urandom); op_b = W'($urandom);
        sub = 1'($urandom); carry_in = 1'($urandom);
    endtask

    task automatic issue4(input logic s, input logic [3:0] a, input logic [3:0] b,
                          input logic ci);
        @(negedge clk);
        start4 = 1; sub4 = s; op_a4 = a; op_b4 = b; carry_in4 = ci;
        @(negedge clk);
        start4 = 0; op_a4 = 4'($urandom);
    endtask

    logic [W-1:0] da [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'hA5A5};
    logic [W-1:0] db [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h5A5B};
    logic         ds [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         dc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            issue(ds[i], da[i], db[i], dc[i]);
            repeat (N + 1) @(negedge clk);
        end

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
            repeat (N + $urandom_range(0, 3)) @(negedge clk);
        end

        // start held high every cycle with changing operands
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1; sub = 1'($urandom); carry_in = 1'($urandom);
            op_a = W'($urandom); op_b = W'($urandom);
        end
        @(negedge clk);
        start = 0;
        repeat (N + 3) @(negedge clk);

        // make sure the held result is non-zero before the abort
        issue(1'b0, 16'h1111, 16'h2222, 1'b1);
        repeat (N + 2) @(negedge clk);

        issue(1'b0, 16'hBEEF, 16'h1357, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_carry", carry_out, 0);
        check("abort_ovf", overflow, 0);
        @(negedge clk);
        #2 rst_n = 1;
        repeat (N + 2) @(negedge clk);
        issue(1'b1, 16'h0100, 16'h0FFF, 1'b0);
        repeat (N + 2) @(negedge clk);

        issue4(1'b0, 4'h9, 4'h8, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            issue4(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end

        repeat (N + 3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        check("queue4_drained", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Multi-precision add/subtract sequencer that reuses one 4-bit ripple adder slice over NIBBLES cycles, one nibble per cycle, LSB first. The carry is held in a flop between nibbles. The block is the area-cheap alternative to a full-width ripple chain. It accepts an operand pair through a start/busy/done handshake and returns a registered result with carry and signed-overflow flags.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4 (elaboration-time check)
NIBBLES, WIDTH/4, derived localparam; number of RUN cycles per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = A+B+carry_in, 1 = A-B (B inverted, carry forced to 1, carry_in ignored); sampled with start
op_a  input  WIDTH  operand A; sampled with start
op_b  input  WIDTH  operand B; sampled with start
carry_in  input  1  add-mode carry in; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse
result  output  WIDTH  registered sum/difference
carry_out  output  1  carry out of the MSB; for subtract, 1 means no borrow
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, and all internal operand/carry/index registers = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE to RUN on start=1:
  - Latch op_a and B' = sub ? ~op_b : op_b into shift registers.
  - carry_reg = sub ? 1 : carry_in.
  - idx=0.
- RUN, every cycle:
  - Slice adds the low nibble of A, the low nibble of B' and carry_reg.
  - Sum nibble shifts into the MSB end of the accumulator.
  - A and B' shift right by 4; carry_reg = slice carry out.
  - idx increments.
- RUN, on the cycle with idx == NIBBLES-1:
  - Transition to DONE.
  - result <= full accumulator including the last nibble.
  - carry_out <= slice carry out.
  - overflow <= (a3 ^ b'3 ^ s3) ^ slice carry out, using the top-nibble bit-3 values.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- Latency: start sampled at edge E0, busy high from E0 to E_NIBBLES, done high in the cycle following E_NIBBLES.
  - WIDTH=16: done is high between edges 4 and 5.
  - The next start is accepted at the earliest at edge NIBBLES+2.
- start in RUN or DONE is ignored; there is no queueing, and the requester must wait for done.
- Operand inputs may change freely after the start edge; only the latched copies are used.
- result, carry_out and overflow update only on the RUN-to-DONE edge. They hold until the next completion, stay stable through IDLE, and are never partially updated.
- WIDTH=4 (NIBBLES=1): RUN lasts one cycle.
- rst_n asserted mid-RUN: the operation is aborted, no done pulse is produced, and all outputs return to reset values immediately.
- Wrap-around: the result is modulo 2^WIDTH; the carry is reported only via carry_out.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE)
  - NIBBLE_W = 4
  - an index-width function clog2 of NIBBLES (minimum 1 bit)
- Natural sub-module: nibble_add_slice, a combinational 4-bit ripple adder slice.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout.
  - Instantiated exactly once.
- Overflow is derived in the controller from the slice's bit-3 inputs and sum; the slice is not modified.

Test Plan:
- WIDTH=16, sub=0, A=0x1234, B=0x4321, carry_in=0 -> done 4 cycles after the start edge; result=0x5555, carry_out=0, overflow=0; busy high for exactly 4 cycles.
- sub=0, A=0xFFFF, B=0x0001, carry_in=0 -> result=0x0000, carry_out=1, overflow=0; this checks carry ripple across all nibble boundaries. Also A=0x7FFF, B=0x0001 -> result=0x8000, overflow=1, carry_out=0.
- sub=1, A=0x0005, B=0x0007, carry_in=1 (ignored) -> result=0xFFFE, carry_out=0 (borrow), overflow=0. Also A=0x8000, B=0x0001 -> result=0x7FFF, overflow=1, carry_out=1.
- start pulsed every cycle with changing operands -> only the IDLE-sampled request is processed, and exactly one done pulse is produced per NIBBLES+2 cycles. Results match the sampled operands, and result holds between done pulses.
- rst_n dropped for one cycle at idx=2 -> busy, done, result, carry_out and overflow read 0 asynchronously, with no done pulse. A fresh start after release completes correctly with the normal latency.
- WIDTH=4 build: A=0x9, B=0x8, sub=0 -> done one cycle after the start edge; result=0x1, carry_out=1, overflow=1.
